// File: rtl/axis_bram_pkg.sv
// Shared state encodings, command record layout and strobe constant for the
// AXIS/BRAM read sequencer and its helpers.
package axis_bram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } rd_state_e;

    // Command record is packed {w_start, r_length, r_start}, each ADDR_WIDTH wide.
    localparam int unsigned CMD_R_START_IDX  = 0;
    localparam int unsigned CMD_R_LENGTH_IDX = 1;
    localparam int unsigned CMD_W_START_IDX  = 2;
    localparam int unsigned CMD_NUM_FIELDS   = 3;

    localparam int unsigned         STRB_MAX_W = 128;
    localparam logic [STRB_MAX_W-1:0] STRB_ALL = '1;

endpackage

// File: rtl/axis_bram_rd_seq_if.sv
// AXI4-Stream bundle used for the bridge-facing input and the framed output
// of the read sequencer.
interface axis_bram_rd_seq_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tlast;

    modport master (output tvalid, tdata, tstrb, tlast, input tready);
    modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry registered skid buffer: registered output payload and an input
// ready that depends only on local state (no ready feed-through).
module axis_skid_buf #(
    parameter int unsigned WIDTH = 65
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o
);
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_fire, out_fire;

    assign s_ready_o = !skid_valid_q;
    assign in_fire   = s_valid_i && !skid_valid_q;
    assign out_fire  = out_valid_q && m_ready_i;
    assign m_valid_o = out_valid_q;
    assign m_data_o  = out_data_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || out_fire) begin
            // Skid entry (older) always drains into the output slot first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_data_d = s_data_i;
                end
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_data_q   <= '0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_data_q   <= out_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/axis_bram_rd_seq.sv
// Read sequencer: queues commands, starts the AXIS/BRAM bridge one command at a
// time and re-frames its beat stream. Optional counters: AXIS_BRAM_RD_SEQ_STATS_EN.
module axis_bram_rd_seq
    import axis_bram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned CMD_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_r_start,
    input  logic [ADDR_WIDTH-1:0] cmd_r_length,
    input  logic [ADDR_WIDTH-1:0] cmd_w_start,
    output logic                  ctrl_axis_m_start,
    output logic [ADDR_WIDTH-1:0] ctrl_r_start_index,
    output logic [ADDR_WIDTH-1:0] ctrl_r_length,
    output logic [ADDR_WIDTH-1:0] ctrl_w_start_index,
    axis_bram_rd_seq_if.slave     s_axis,
    axis_bram_rd_seq_if.master    m_axis,
    output logic                  busy,
    output logic                  done,
    output logic                  err_zero_len
`ifdef AXIS_BRAM_RD_SEQ_STATS_EN
   ,input  logic                  stat_clr,
    output logic [31:0]           stat_cmds,
    output logic [31:0]           stat_beats
`endif
);
    localparam int unsigned PTR_W  = $clog2(CMD_FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned CMD_W  = CMD_NUM_FIELDS * ADDR_WIDTH;
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic [CMD_W-1:0]      fifo_mem_q [CMD_FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  fifo_empty, fifo_full, push, pop;
    logic [CMD_W-1:0]      head;
    logic [ADDR_WIDTH-1:0] head_r_start, head_r_length, head_w_start;

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                  ld_ctrl, err_d, done_d, err_q, done_q;

    logic                  skid_s_ready, skid_m_valid, s_fire, m_fire;
    logic [DATA_WIDTH:0]   skid_m_data;

    // Command FIFO
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(CMD_FIFO_DEPTH));
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign head       = fifo_mem_q[rd_ptr_q];

    assign head_r_start  = head[CMD_R_START_IDX*ADDR_WIDTH  +: ADDR_WIDTH];
    assign head_r_length = head[CMD_R_LENGTH_IDX*ADDR_WIDTH +: ADDR_WIDTH];
    assign head_w_start  = head[CMD_W_START_IDX*ADDR_WIDTH  +: ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {cmd_w_start, cmd_r_length, cmd_r_start};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sequencer FSM
    assign s_fire = s_axis.tvalid && s_axis.tready;
    assign m_fire = skid_m_valid && m_axis.tready;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        pop        = 1'b0;
        ld_ctrl    = 1'b0;
        err_d      = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    ld_ctrl = 1'b1;
                    if (head_r_length == '0) err_d   = 1'b1;
                    else                     state_d = ISSUE;
                end
            end
            ISSUE: begin
                beat_cnt_d = ctrl_r_length;
                state_d    = STREAM;
            end
            STREAM: begin
                if (s_fire) begin
                    beat_cnt_d = beat_cnt_q - ADDR_WIDTH'(1);
                    if (beat_cnt_q == ADDR_WIDTH'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (m_fire && skid_m_data[DATA_WIDTH]) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= IDLE;
            beat_cnt_q         <= '0;
            err_q              <= 1'b0;
            done_q             <= 1'b0;
            ctrl_r_start_index <= '0;
            ctrl_r_length      <= '0;
            ctrl_w_start_index <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
            if (ld_ctrl) begin
                ctrl_r_start_index <= head_r_start;
                ctrl_r_length      <= head_r_length;
                ctrl_w_start_index <= head_w_start;
            end
        end
    end

    assign ctrl_axis_m_start = (state_q == ISSUE);
    assign err_zero_len      = err_q;
    assign done              = done_q;
    assign s_axis.tready     = (state_q == STREAM) && skid_s_ready;
    assign busy              = (state_q != IDLE) || skid_m_valid || !fifo_empty;

    // Output framing: tlast is tagged on the beat that takes the count to zero.
    axis_skid_buf #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_valid_i (s_axis.tvalid && (state_q == STREAM)),
        .s_ready_o (skid_s_ready),
        .s_data_i  ({(beat_cnt_q == ADDR_WIDTH'(1)), s_axis.tdata}),
        .m_valid_o (skid_m_valid),
        .m_ready_i (m_axis.tready),
        .m_data_o  (skid_m_data)
    );

    assign m_axis.tvalid = skid_m_valid;
    assign m_axis.tdata  = skid_m_data[DATA_WIDTH-1:0];
    assign m_axis.tlast  = skid_m_data[DATA_WIDTH];
    assign m_axis.tstrb  = skid_m_valid ? STRB_ALL[STRB_W-1:0] : '0;

`ifdef AXIS_BRAM_RD_SEQ_STATS_EN
    logic [31:0] stat_cmds_q, stat_beats_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_cmds_q  <= '0;
            stat_beats_q <= '0;
        end else if (stat_clr) begin
            stat_cmds_q  <= '0;
            stat_beats_q <= '0;
        end else begin
            if (done_d) stat_cmds_q  <= stat_cmds_q + 32'd1;
            if (m_fire) stat_beats_q <= stat_beats_q + 32'd1;
        end
    end

    assign stat_cmds  = stat_cmds_q;
    assign stat_beats = stat_beats_q;
`endif

endmodule

// File: tb/tb_axis_bram_rd_seq.sv
// Scoreboard bench for axis_bram_rd_seq with a behavioural bridge model.
`timescale 1ns/1ps
module tb_axis_bram_rd_seq;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] cmd_r_start, cmd_r_length, cmd_w_start;
    logic          ctrl_axis_m_start;
    logic [AW-1:0] ctrl_r_start_index, ctrl_r_length, ctrl_w_start_index;
    logic          busy, done, err_zero_len;
`ifdef AXIS_BRAM_RD_SEQ_STATS_EN
    logic          stat_clr;
    logic [31:0]   stat_cmds, stat_beats;
`endif

    axis_bram_rd_seq_if #(.DATA_WIDTH(DW)) s_axis_if ();
    axis_bram_rd_seq_if #(.DATA_WIDTH(DW)) m_axis_if ();

    axis_bram_rd_seq #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .CMD_FIFO_DEPTH (4)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_r_start        (cmd_r_start),
        .cmd_r_length       (cmd_r_length),
        .cmd_w_start        (cmd_w_start),
        .ctrl_axis_m_start  (ctrl_axis_m_start),
        .ctrl_r_start_index (ctrl_r_start_index),
        .ctrl_r_length      (ctrl_r_length),
        .ctrl_w_start_index (ctrl_w_start_index),
        .s_axis             (s_axis_if),
        .m_axis             (m_axis_if),
        .busy               (busy),
        .done               (done),
        .err_zero_len       (err_zero_len)
`ifdef AXIS_BRAM_RD_SEQ_STATS_EN
       ,.stat_clr           (stat_clr),
        .stat_cmds          (stat_cmds),
        .stat_beats         (stat_beats)
`endif
    );

    typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct packed { logic [AW-1:0] r; logic [AW-1:0] len; logic [AW-1:0] w; } cmd_t;

    beat_t exp_q[$];
    cmd_t  exp_cmd_q[$];

    int unsigned n_checks = 0, n_errors = 0;
    int unsigned n_beats = 0, n_starts = 0, n_dones = 0, n_errs_seen = 0;
    int unsigned beats_since_rst = 0, dones_since_rst = 0, occ = 0;
    int unsigned mode = 0;
    logic        surplus = 1'b0;
    logic        prev_last_fire = 1'b0;
    logic        br_start_s = 1'b0, br_fire_s = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input logic [31:0] w, input logic [31:0] a);
        return {w ^ 32'h5A5A_0000, a};
    endfunction

    // Bridge model: streams ctrl_r_length beats from ctrl_r_start_index after each start pulse.
    logic [31:0] br_addr = '0, br_w = '0;
    int unsigned br_rem = 0;
    initial begin
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tdata  = '0;
        s_axis_if.tstrb  = '0;
        s_axis_if.tlast  = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!reset_n) br_rem = 0;
            else if (br_start_s) begin
                br_addr = 32'(ctrl_r_start_index);
                br_w    = 32'(ctrl_w_start_index);
                br_rem  = int'(ctrl_r_length);
            end else if (br_fire_s && br_rem != 0) begin
                br_addr++;
                br_rem--;
            end
            s_axis_if.tvalid = (br_rem != 0) || surplus;
            s_axis_if.tdata  = (br_rem != 0) ? mk_data(br_w, br_addr) : 64'hDEAD_BEEF_0BAD_F00D;
            s_axis_if.tlast  = (br_rem == 2);
        end
    end

    initial begin
        m_axis_if.tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (mode)
                0:       m_axis_if.tready = 1'b1;
                1:       m_axis_if.tready = ~m_axis_if.tready;
                default: m_axis_if.tready = 1'b0;
            endcase
        end
    end

    // Monitor, sampled on the falling edge.
    initial begin
        beat_t b;
        cmd_t  c;
        logic  m_fire;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                occ = 0; prev_last_fire = 1'b0; br_start_s = 1'b0; br_fire_s = 1'b0;
                beats_since_rst = 0; dones_since_rst = 0;
                continue;
            end
            br_start_s = ctrl_axis_m_start;
            br_fire_s  = s_axis_if.tvalid && s_axis_if.tready;
            if (occ == 2) check("skid_full_rdy", s_axis_if.tready, 0);
            if (done || prev_last_fire) check("done_timing", done, prev_last_fire);
            if (done) begin n_dones++; dones_since_rst++; end
            if (err_zero_len) n_errs_seen++;
            if (ctrl_axis_m_start) begin
                n_starts++;
                if (exp_cmd_q.size() == 0) check("start_unexp", ctrl_axis_m_start, 0);
                else begin
                    c = exp_cmd_q.pop_front();
                    check("ctrl_r_start", ctrl_r_start_index, c.r);
                    check("ctrl_r_length", ctrl_r_length, c.len);
                    check("ctrl_w_start", ctrl_w_start_index, c.w);
                end
            end
            m_fire = m_axis_if.tvalid && m_axis_if.tready;
            if (m_fire) begin
                n_beats++; beats_since_rst++;
                if (exp_q.size() == 0) check("beat_unexp", m_axis_if.tvalid, 0);
                else begin
                    b = exp_q.pop_front();
                    check("tdata", m_axis_if.tdata, b.data);
                    check("tlast", m_axis_if.tlast, b.last);
                end
                check("tstrb", m_axis_if.tstrb, 64'hFF);
            end
            if (br_fire_s && !m_fire) occ++;
            else if (!br_fire_s && m_fire && occ > 0) occ--;
            prev_last_fire = m_fire && m_axis_if.tlast;
        end
    end

    task automatic push_cmd(input logic [AW-1:0] r, input logic [AW-1:0] len,
                            input logic [AW-1:0] w, input int budget, output bit ok);
        logic rdy;
        cmd_t c;
        ok = 1'b0;
        cmd_valid = 1'b1; cmd_r_start = r; cmd_r_length = len; cmd_w_start = w;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); rdy = cmd_ready;
            @(posedge clk); #1;
            if (rdy) begin ok = 1'b1; break; end
        end
        cmd_valid = 1'b0;
        if (ok && len != 0) begin
            c.r = r; c.len = len; c.w = w;
            exp_cmd_q.push_back(c);
            for (int unsigned i = 0; i < int'(len); i++) begin
                b_push(mk_data(32'(w), 32'(r) + 32'(i)), (i == int'(len) - 1));
            end
        end
    endtask

    task automatic b_push(input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.data = d; b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic send(input logic [AW-1:0] r, input logic [AW-1:0] len, input logic [AW-1:0] w);
        bit ok;
        push_cmd(r, len, w, 200, ok);
        check("push_ok", ok, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
        end
        check("idle_busy", busy, 0);
        check("sb_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_rst_outputs();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_start", ctrl_axis_m_start, 0);
        check("rst_ctrl", {ctrl_r_start_index, ctrl_r_length, ctrl_w_start_index}, 0);
        check("rst_s_tready", s_axis_if.tready, 0);
        check("rst_m_tvalid", m_axis_if.tvalid, 0);
        check("rst_m_tdata", m_axis_if.tdata, 0);
        check("rst_m_tlast_strb", {m_axis_if.tlast, m_axis_if.tstrb}, 0);
        check("rst_flags", {busy, done, err_zero_len}, 0);
    endtask

    initial begin
        int unsigned bs, bd, bb, be;
        bit ok;
        cmd_valid = 1'b0; cmd_r_start = '0; cmd_r_length = '0; cmd_w_start = '0;
`ifdef AXIS_BRAM_RD_SEQ_STATS_EN
        stat_clr = 1'b0;
`endif
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_rst_outputs();
        @(posedge clk); #3 reset_n = 1'b1;
        @(posedge clk); #1;

        // Single command, len 4
        mode = 0; bs = n_starts; bd = n_dones; bb = n_beats;
        send(12'h010, 12'd4, 12'h100);
        wait_idle(100);
        check("t1_starts", n_starts - bs, 1);
        check("t1_beats", n_beats - bb, 4);
        check("t1_dones", n_dones - bd, 1);

        // Three back-to-back commands
        bs = n_starts; bd = n_dones; bb = n_beats;
        send(12'h020, 12'd1, 12'h200);
        send(12'h030, 12'd2, 12'h210);
        send(12'h040, 12'd3, 12'h220);
        wait_idle(200);
        check("t2_starts", n_starts - bs, 3);
        check("t2_beats", n_beats - bb, 6);
        check("t2_dones", n_dones - bd, 3);

        // Zero length then len 2
        bs = n_starts; be = n_errs_seen; bb = n_beats;
        send(12'h050, 12'd0, 12'h300);
        send(12'h060, 12'd2, 12'h310);
        wait_idle(100);
        check("t3_err", n_errs_seen - be, 1);
        check("t3_starts", n_starts - bs, 1);
        check("t3_beats", n_beats - bb, 2);

        // Toggling downstream ready with a bridge that always offers data
        mode = 1; surplus = 1'b1; bb = n_beats;
        send(12'h0F8, 12'd8, 12'h400);
        wait_idle(200);
        surplus = 1'b0; mode = 0;
        repeat (2) @(posedge clk); #1;
        check("t4_beats", n_beats - bb, 8);

        // Fill the command queue behind a stalled command
        mode = 2;
        send(12'h100, 12'd2, 12'h500);
        repeat (6) @(posedge clk); #1;
        for (int unsigned i = 0; i < 4; i++) send(12'h110 + AW'(i * 16), 12'd1, 12'h510);
        @(negedge clk);
        check("t5_full_rdy", cmd_ready, 0);
        @(posedge clk); #1;
        push_cmd(12'h180, 12'd1, 12'h520, 6, ok);
        check("t5_blocked", ok, 0);
        bd = n_dones;
        mode = 0;
        push_cmd(12'h180, 12'd1, 12'h520, 300, ok);
        check("t5_accepted", ok, 1);
        check("t5_after_pop", n_dones > bd, 1);
        wait_idle(300);

        // Asynchronous reset mid-stream
        bb = n_beats;
        send(12'h200, 12'd8, 12'h600);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (n_beats - bb >= 3) break;
        end
        check("t6_reached_beat3", n_beats - bb, 3);
        #2 reset_n = 1'b0;
        #1 check_rst_outputs();
        exp_q.delete(); exp_cmd_q.delete();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        bb = n_beats;
        send(12'h240, 12'd3, 12'h610);
        wait_idle(100);
        check("t6_beats", n_beats - bb, 3);
`ifdef AXIS_BRAM_RD_SEQ_STATS_EN
        check("stat_beats", stat_beats, 64'(beats_since_rst));
        check("stat_cmds", stat_cmds, 64'(dones_since_rst));
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        check("stat_clr", {stat_cmds, stat_beats}, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
